// File: rtl/eth_ts_frame_gen.sv
// Free-running Ethernet test-frame generator: fixed-length frames carrying a
// sequence number and a transmit timestamp, emitted as 64-bit AXI-Stream beats.
module eth_ts_frame_gen #(
  parameter int unsigned FRAME_WORDS = 8,
  parameter logic [7:0]  LAST_KEEP   = 8'hFF,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
  input  logic        clk156,
  input  logic        aresetn,
  input  logic        enable,
  output logic        m_axis_tx_tvalid,
  input  logic        m_axis_tx_tready,
  output logic [63:0] m_axis_tx_tdata,
  output logic [7:0]  m_axis_tx_tkeep,
  output logic        m_axis_tx_tlast,
  output logic        m_axis_tx_tuser,
  output logic [31:0] frame_count,
  output logic        busy
);

  localparam logic [7:0]  LAST_IDX = 8'(FRAME_WORDS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  rst_sync;
  logic        rst_n;
  logic [63:0] ts;
  logic [63:0] ts_cap;
  logic [31:0] seq;
  logic [7:0]  beat_idx;
  logic [7:0]  beat_nxt;
  logic [15:0] gap_cnt;
  logic        hs;
  logic        last_hs;

  // Fields are assembled big-endian (wire byte 0 in the MSBs), then flipped so
  // that wire byte n lands in tdata[8n+7:8n].
  function automatic logic [63:0] wire_order(input logic [63:0] be);
    logic [63:0] w;
    w = 64'h0;
    for (int n = 0; n < 8; n++) w[8*n +: 8] = be[63-8*n -: 8];
    return w;
  endfunction

  function automatic logic [63:0] beat_word(input logic [7:0]  idx,
                                            input logic [31:0] s,
                                            input logic [63:0] tc);
    logic [63:0] be;
    case (idx)
      8'd0:    be = {DST_MAC, SRC_MAC[47:32]};
      8'd1:    be = {SRC_MAC[31:0], ETHERTYPE, 16'h0000};
      8'd2:    be = {s, 32'h0000_0000};
      8'd3:    be = tc;
      default: be = 64'h0;
    endcase
    return wire_order(be);
  endfunction

  function automatic logic [7:0] beat_keep(input logic [7:0] idx);
    return (idx == LAST_IDX) ? LAST_KEEP : 8'hFF;
  endfunction

  // Assertion is immediate; release is delayed by two flops.
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n           = rst_sync[1];
  assign m_axis_tx_tuser = 1'b0;
  assign frame_count     = seq;
  assign hs              = m_axis_tx_tvalid & m_axis_tx_tready;
  assign last_hs         = hs && (beat_idx == LAST_IDX);
  assign beat_nxt        = beat_idx + 8'd1;

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) ts <= 64'h0;
    else        ts <= ts + 64'd1;
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = SEND;
      SEND:    if (last_hs) state_next = HAS_GAP ? GAP : IDLE;
      GAP:     if (gap_cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tx_tvalid <= 1'b0;
      m_axis_tx_tdata  <= 64'h0;
      m_axis_tx_tkeep  <= 8'h00;
      m_axis_tx_tlast  <= 1'b0;
      busy             <= 1'b0;
      beat_idx         <= 8'd0;
      gap_cnt          <= 16'd0;
      ts_cap           <= 64'h0;
      seq              <= 32'd0;
    end else begin
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (enable) begin
            m_axis_tx_tvalid <= 1'b1;
            m_axis_tx_tdata  <= beat_word(8'd0, seq, ts_cap);
            m_axis_tx_tkeep  <= beat_keep(8'd0);
            m_axis_tx_tlast  <= (LAST_IDX == 8'd0);
            beat_idx         <= 8'd0;
          end
        end
        SEND: begin
          if (hs) begin
            if (beat_idx == 8'd0) ts_cap <= ts;
            if (last_hs) begin
              m_axis_tx_tvalid <= 1'b0;
              m_axis_tx_tdata  <= 64'h0;
              m_axis_tx_tkeep  <= 8'h00;
              m_axis_tx_tlast  <= 1'b0;
              seq              <= seq + 32'd1;
              gap_cnt          <= 16'd0;
            end else begin
              // ts_cap is already valid here: beat 3 loads at least two edges after beat 0.
              beat_idx         <= beat_nxt;
              m_axis_tx_tdata  <= beat_word(beat_nxt, seq, ts_cap);
              m_axis_tx_tkeep  <= beat_keep(beat_nxt);
              m_axis_tx_tlast  <= (beat_nxt == LAST_IDX);
            end
          end
        end
        GAP:     gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_ts_frame_gen.sv
// Directed bench for eth_ts_frame_gen: one default instance (8 beats, no gap)
// and one with 4 beats, LAST_KEEP=8'h0F and a 3-cycle gap.
module tb_eth_ts_frame_gen;

  logic clk = 1'b0;
  logic rstn0 = 1'b0, rstn1 = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic rdy0 = 1'b1, rdy1 = 1'b1;

  logic        vld0, last0, user0, busy0;
  logic [63:0] data0;
  logic [7:0]  keep0;
  logic [31:0] fc0;
  logic        vld1, last1, user1, busy1;
  logic [63:0] data1;
  logic [7:0]  keep1;
  logic [31:0] fc1;

  int cyc = 0;
  int r0 = 0;
  int r1 = 0;
  int n_cmp = 0;
  int n_bad = 0;

  eth_ts_frame_gen dut0 (
    .clk156(clk), .aresetn(rstn0), .enable(en0),
    .m_axis_tx_tvalid(vld0), .m_axis_tx_tready(rdy0), .m_axis_tx_tdata(data0),
    .m_axis_tx_tkeep(keep0), .m_axis_tx_tlast(last0), .m_axis_tx_tuser(user0),
    .frame_count(fc0), .busy(busy0)
  );

  eth_ts_frame_gen #(.FRAME_WORDS(4), .LAST_KEEP(8'h0F), .GAP_CYCLES(3)) dut1 (
    .clk156(clk), .aresetn(rstn1), .enable(en1),
    .m_axis_tx_tvalid(vld1), .m_axis_tx_tready(rdy1), .m_axis_tx_tdata(data1),
    .m_axis_tx_tkeep(keep1), .m_axis_tx_tlast(last1), .m_axis_tx_tuser(user1),
    .frame_count(fc1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected tdata per beat for the default MACs/EtherType (wire byte 0 in bits [7:0]).
  function automatic logic [63:0] exp_word(int k, logic [31:0] s, logic [63:0] t);
    case (k)
      0:       return 64'h0002_FFFF_FFFF_FFFF;
      1:       return 64'h0000_B588_0100_0000;
      2:       return {32'h0, s[7:0], s[15:8], s[23:16], s[31:24]};
      3:       return {t[7:0], t[15:8], t[23:16], t[31:24], t[39:32], t[47:40], t[55:48], t[63:56]};
      default: return 64'h0;
    endcase
  endfunction

  // ts counts from 0 starting two edges after aresetn release (cycle r).
  function automatic logic [63:0] ts_at(int c, int r);
    return 64'(c - r - 2);
  endfunction

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if ({vld0, last0, user0, busy0} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctl0: got %b, want 0000", {vld0, last0, user0, busy0});
    end
    n_cmp++;
    if (data0 !== 64'h0 || keep0 !== 8'h00) begin
      n_bad++; $display("FAIL reset_data0: got data=%h keep=%h, want 0/0", data0, keep0);
    end
    n_cmp++;
    if (fc0 !== 32'd0) begin
      n_bad++; $display("FAIL reset_fc0: got %0d, want 0", fc0);
    end
    n_cmp++;
    if ({vld1, last1, user1, busy1, keep1} !== 12'h000 || data1 !== 64'h0 || fc1 !== 32'd0) begin
      n_bad++; $display("FAIL reset_dut1: got vld=%b data=%h keep=%h fc=%0d, want zeros", vld1, data1, keep1, fc1);
    end
    rstn0 = 1'b1; rstn1 = 1'b1;
    r0 = cyc; r1 = cyc;
    repeat (2) tick();
    n_cmp++;
    if (vld0 !== 1'b0 || busy0 !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_release: got vld=%b busy=%b, want 0/0", vld0, busy0);
    end
  endtask

  task automatic test_basic_frame();
    int c;
    logic [63:0] t;
    while (cyc < r0 + 10) tick();
    en0 = 1'b1; c = cyc;
    tick();
    en0 = 1'b0;
    t = ts_at(c + 1, r0);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (vld0 !== 1'b1 || data0 !== exp_word(k, 32'd0, t)) begin
        n_bad++; $display("FAIL basic_beat%0d: got vld=%b data=%h, want 1 %h", k, vld0, data0, exp_word(k, 32'd0, t));
      end
      n_cmp++;
      if (keep0 !== 8'hFF || last0 !== (k == 7) || busy0 !== 1'b1) begin
        n_bad++; $display("FAIL basic_ctl%0d: got keep=%h last=%b busy=%b, want FF %b 1", k, keep0, last0, busy0, (k == 7));
      end
      tick();
    end
    n_cmp++;
    if (vld0 !== 1'b0 || fc0 !== 32'd1 || busy0 !== 1'b0) begin
      n_bad++; $display("FAIL basic_end: got vld=%b fc=%0d busy=%b, want 0 1 0", vld0, fc0, busy0);
    end
  endtask

  task automatic test_backpressure();
    int c;
    logic [63:0] t;
    c = cyc; en0 = 1'b1;
    tick();
    en0 = 1'b0;
    t = ts_at(c + 1, r0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        rdy0 = 1'b0;
        for (int j = 0; j < 5; j++) begin
          n_cmp++;
          if (vld0 !== 1'b1 || data0 !== exp_word(3, 32'd1, t)) begin
            n_bad++; $display("FAIL stall%0d: got vld=%b data=%h, want 1 %h", j, vld0, data0, exp_word(3, 32'd1, t));
          end
          tick();
        end
        rdy0 = 1'b1;
      end
      n_cmp++;
      if (vld0 !== 1'b1 || data0 !== exp_word(k, 32'd1, t) || last0 !== (k == 7)) begin
        n_bad++; $display("FAIL bp_beat%0d: got vld=%b data=%h last=%b, want 1 %h %b", k, vld0, data0, last0, exp_word(k, 32'd1, t), (k == 7));
      end
      tick();
    end
    n_cmp++;
    if (vld0 !== 1'b0 || fc0 !== 32'd2) begin
      n_bad++; $display("FAIL bp_end: got vld=%b fc=%0d, want 0 2", vld0, fc0);
    end
  endtask

  task automatic test_gap_sequence();
    int c;
    logic [63:0] t;
    c = cyc; en1 = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      t = ts_at(c + 1 + 8 * f, r1);
      if (f == 2) en1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (vld1 !== 1'b1 || data1 !== exp_word(k, 32'(f), t)) begin
          n_bad++; $display("FAIL gap_f%0d_beat%0d: got vld=%b data=%h, want 1 %h", f, k, vld1, data1, exp_word(k, 32'(f), t));
        end
        n_cmp++;
        if (keep1 !== ((k == 3) ? 8'h0F : 8'hFF) || last1 !== (k == 3)) begin
          n_bad++; $display("FAIL keep_f%0d_beat%0d: got keep=%h last=%b, want %h %b", f, k, keep1, last1, ((k == 3) ? 8'h0F : 8'hFF), (k == 3));
        end
        tick();
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (vld1 !== 1'b0 || busy1 !== (i < 3)) begin
          n_bad++; $display("FAIL gap_idle_f%0d_%0d: got vld=%b busy=%b, want 0 %b", f, i, vld1, busy1, (i < 3));
        end
        if (i == 0) begin
          n_cmp++;
          if (fc1 !== 32'(f + 1)) begin
            n_bad++; $display("FAIL gap_fc_f%0d: got %0d, want %0d", f, fc1, f + 1);
          end
        end
        tick();
      end
    end
    n_cmp++;
    if (vld1 !== 1'b0 || fc1 !== 32'd3) begin
      n_bad++; $display("FAIL gap_end: got vld=%b fc=%0d, want 0 3", vld1, fc1);
    end
  endtask

  task automatic test_enable_drop();
    int c;
    logic [63:0] t;
    c = cyc; en1 = 1'b1;
    tick();
    t = ts_at(c + 1, r1);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) en1 = 1'b0;
      n_cmp++;
      if (vld1 !== 1'b1 || data1 !== exp_word(k, 32'd3, t) || last1 !== (k == 3)) begin
        n_bad++; $display("FAIL drop_beat%0d: got vld=%b data=%h last=%b, want 1 %h %b", k, vld1, data1, last1, exp_word(k, 32'd3, t), (k == 3));
      end
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (vld1 !== 1'b0 || busy1 !== (i < 3)) begin
        n_bad++; $display("FAIL drop_after%0d: got vld=%b busy=%b, want 0 %b", i, vld1, busy1, (i < 3));
      end
      tick();
    end
    n_cmp++;
    if (fc1 !== 32'd4) begin
      n_bad++; $display("FAIL drop_fc: got %0d, want 4", fc1);
    end
  endtask

  task automatic test_reset_mid_frame();
    en0 = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (vld0 !== 1'b1 || data0 !== 64'h0 || last0 !== 1'b0) begin
      n_bad++; $display("FAIL pre_reset_beat5: got vld=%b data=%h last=%b, want 1 0 0", vld0, data0, last0);
    end
    rstn0 = 1'b0;
    #1;
    n_cmp++;
    if (vld0 !== 1'b0 || fc0 !== 32'd0 || data0 !== 64'h0 || busy0 !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got vld=%b fc=%0d data=%h busy=%b, want 0 0 0 0", vld0, fc0, data0, busy0);
    end
    repeat (2) tick();
    rstn0 = 1'b1; r0 = cyc;
    for (int i = 1; i < 3; i++) begin
      tick();
      n_cmp++;
      if (vld0 !== 1'b0) begin
        n_bad++; $display("FAIL sync_release%0d: got vld=%b, want 0", i, vld0);
      end
    end
    tick();
    en0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (vld0 !== 1'b1 || data0 !== exp_word(k, 32'd0, 64'd1)) begin
        n_bad++; $display("FAIL restart_beat%0d: got vld=%b data=%h, want 1 %h", k, vld0, data0, exp_word(k, 32'd0, 64'd1));
      end
      tick();
    end
    n_cmp++;
    if (vld0 !== 1'b0 || fc0 !== 32'd1) begin
      n_bad++; $display("FAIL restart_fc: got vld=%b fc=%0d, want 0 1", vld0, fc0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_gap_sequence();
    test_enable_drop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
